seq_mem_d1_streamer: RTL

Sequential read engine that sits directly downstream of a `seq_mem_d1` instance. It accepts a (base, length) command, drives the memory's read port one address per cycle, and emits the returned words in order on a valid/ready output stream. An internal 2-entry buffer absorbs consumer backpressure without losing in-flight reads.

---
 rtl/seq_mem_d1_streamer_pkg.sv | 12 +
 rtl/seq_mem_d1_streamer_if.sv | 31 +++
 rtl/seq_mem_d1_streamer_fifo.sv | 54 +++++
 rtl/seq_mem_d1_streamer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seq_mem_d1_streamer_pkg.sv
// Shared types and constants for the seq_mem_d1 streaming read engines.
package seq_mem_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_e;

  localparam int unsigned STREAM_FIFO_DEPTH = 2;

endpackage

// File: rtl/seq_mem_d1_streamer_if.sv
// Command, memory read port and output stream signals of the streamer.
// The slave modport is the streamer's view; master is the environment's view.
interface seq_mem_d1_streamer_if #(
  parameter int WIDTH     = 32,
  parameter int IDX_SIZE  = 4,
  parameter int LEN_WIDTH = IDX_SIZE + 1
);
  logic                 start_valid;
  logic                 start_ready;
  logic [IDX_SIZE-1:0]  base;
  logic [LEN_WIDTH-1:0] len;
  logic [IDX_SIZE-1:0]  mem_addr0;
  logic                 mem_read_en;
  logic [WIDTH-1:0]     mem_out;
  logic                 mem_read_done;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 done;
  logic                 err;

  modport slave (
    input  start_valid, base, len, mem_out, mem_read_done, out_ready,
    output start_ready, mem_addr0, mem_read_en, out_data, out_valid, done, err
  );

  modport master (
    output start_valid, base, len, mem_out, mem_read_done, out_ready,
    input  start_ready, mem_addr0, mem_read_en, out_data, out_valid, done, err
  );
endinterface

// File: rtl/seq_mem_d1_streamer_fifo.sv
// Two-entry register FIFO. head is the oldest entry and only changes on a pop
// (or on a push into an empty FIFO), so it is stable while the consumer stalls.
module stream_fifo2
  import seq_mem_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'(STREAM_FIFO_DEPTH)) | do_pop);

  // Storage and occupancy update; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_mem_d1_streamer.sv
// Sequential read engine for seq_mem_d1: accepts (base, len), issues one read
// per cycle with address wrap, and streams the returned words through a
// two-entry FIFO so that backpressure never drops an in-flight read.
module seq_mem_d1_streamer
  import seq_mem_stream_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 16,
  parameter int IDX_SIZE  = 4,
  parameter int LEN_WIDTH = IDX_SIZE + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  seq_mem_d1_streamer_if.slave  bus
);

  localparam logic [LEN_WIDTH-1:0] SIZE_L    = LEN_WIDTH'(SIZE);
  localparam logic [IDX_SIZE-1:0]  ADDR_LAST = IDX_SIZE'(SIZE - 1);

  stream_state_e        state, state_next;
  logic [IDX_SIZE-1:0]  addr;
  logic [LEN_WIDTH-1:0] issue_cnt;
  logic [LEN_WIDTH-1:0] accept_cnt;
  logic                 inflight;
  logic [1:0]           fifo_count;
  logic [WIDTH-1:0]     fifo_head;
  logic                 pop;
  logic                 room;
  logic                 issue;
  logic                 cmd_load;
  logic                 cmd_bad;
  logic                 done_next;
  logic                 err_next;
  logic                 done_q;
  logic                 err_q;
  logic [2:0]           occupancy;

  assign pop       = bus.out_valid & bus.out_ready;
  assign cmd_bad   = (LEN_WIDTH'(bus.base) >= SIZE_L) || (bus.len > SIZE_L);
  // Entries held plus the read still returning, less the word leaving now.
  assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign room      = occupancy < 3'(STREAM_FIFO_DEPTH);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, read issue and command decode.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    cmd_load   = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_valid) begin
          if (cmd_bad) begin
            err_next = 1'b1;
          end else if (bus.len == '0) begin
            done_next = 1'b1;
          end else begin
            cmd_load   = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if ((issue_cnt != '0) && room) begin
          issue = 1'b1;
          if (issue_cnt == LEN_WIDTH'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (accept_cnt == LEN_WIDTH'(1))) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address/issue/accept counters, in-flight flag and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      inflight   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (cmd_load) begin
        addr       <= bus.base;
        issue_cnt  <= bus.len;
        accept_cnt <= bus.len;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt - LEN_WIDTH'(1);
          addr      <= (addr == ADDR_LAST) ? '0 : addr + IDX_SIZE'(1);
        end
        if (pop) accept_cnt <= accept_cnt - LEN_WIDTH'(1);
      end
      if (issue)                  inflight <= 1'b1;
      else if (bus.mem_read_done) inflight <= 1'b0;
      done_q <= done_next;
      err_q  <= err_next;
    end
  end

  stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.mem_read_done),
    .push_data (bus.mem_out),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.start_ready = (state == IDLE) & ~reset;
  assign bus.mem_read_en = issue;
  assign bus.mem_addr0   = issue ? addr : '0;
  assign bus.out_data    = fifo_head;
  assign bus.out_valid   = (fifo_count != 2'd0);
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
